// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: breaks the ready path between downstream and
// upstream while keeping full throughput and strict FIFO order.
module pipe_skid_reg #(
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  bp_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  bp_cnt_q;
  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and entry-load decode; flush overrides any handshake
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so no ready path leaks through
  always_comb begin
    in_ready_o  = (state_q != ST_FULL);
    out_valid_o = (state_q != ST_EMPTY);
    count_o     = state_q;
  end

  // Payload entries; main always drives the output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      if (CLEAR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_q <= in_data_i;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data_i;
      end
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bp_cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i && (bp_cnt_q != CNT_MAX)) begin
      bp_cnt_q <= bp_cnt_q + CNT_W'(1);
    end
  end

  assign out_data_o = main_q;
  assign bp_cnt_o   = bp_cnt_q;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter CLEAR_ON_FLUSH, default 1: when 1, flush zeroes the stored payloads; when 0, payloads are retained.
REQ-003 SHALL have parameter CNT_W, default 16: width of the backpressure counter.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port flush_i, input, 1: discards all held entries.
REQ-007 SHALL have port in_valid_i, input, 1: upstream payload valid.
REQ-008 SHALL have port in_ready_o, output, 1: block can accept this cycle.
REQ-009 SHALL have port in_data_i, input, DATA_W: upstream payload.
REQ-010 SHALL have port out_valid_o, output, 1: downstream payload valid.
REQ-011 SHALL have port out_ready_i, input, 1: downstream accepts.
REQ-012 SHALL have port out_data_o, output, DATA_W: downstream payload.
REQ-013 SHALL have port count_o, output, 2: occupancy, 0..2.
REQ-014 SHALL have port bp_cnt_o, output, CNT_W: backpressure cycle counter.

Function
REQ-015 SHALL hold two entries: main (drives out_data_o) and skid; state EMPTY(0), ONE(1), FULL(2), count_o equal to state.
REQ-016 SHALL define in-fire = in_valid_i & in_ready_o and out-fire = out_valid_o & out_ready_i.
REQ-017 SHALL drive in_ready_o = (state != FULL), and out_valid_o = (state != EMPTY), both directly from registers (no combinational path from out_ready_i to in_ready_o).
REQ-018 SHALL transition from EMPTY on in-fire to ONE with main <= in_data_i; otherwise stay EMPTY.
REQ-019 SHALL in ONE: in-fire & out-fire -> ONE, main <= in_data_i; in-fire only -> FULL, skid <= in_data_i; out-fire only -> EMPTY; neither -> ONE unchanged.
REQ-020 SHALL in FULL: out-fire -> ONE, main <= skid; else FULL unchanged; in_valid_i ignored.
REQ-021 SHALL give a latency of exactly 1 cycle from in-fire to out_valid_o when EMPTY, and preserve strict FIFO order.
REQ-022 SHALL keep out_data_o stable while out_valid_o=1 and out_ready_i=0.
REQ-023 SHALL on flush_i=1 (rst_i=0) go to EMPTY next cycle regardless of in-fire/out-fire that cycle; an in-fire coincident with flush is dropped; main and skid zeroed if CLEAR_ON_FLUSH=1, else retained.
REQ-024 SHALL increment bp_cnt_o each cycle with out_valid_o=1 and out_ready_i=0, saturating at 2^CNT_W-1 with no wrap; flush does not clear it.
REQ-025 SHALL give priority rst_i > flush_i > handshake updates.

Reset
REQ-026 SHALL on rst_i=1 at a clock edge set state EMPTY, count_o=0, out_valid_o=0, in_ready_o=1, main=0, skid=0, out_data_o=0, bp_cnt_o=0, regardless of parameters.
REQ-027 SHALL, when reset is asserted mid-transfer in FULL, lose both entries with no output pulse afterwards.

Verification
REQ-028 SHALL cover streaming: out_ready_i=1, in_valid_i=1 for data 0x1,0x2,0x3 on consecutive cycles -> out_data_o 0x1,0x2,0x3 one cycle later, count_o=1 throughout, bp_cnt_o=0.
REQ-029 SHALL cover fill: out_ready_i=0, send 0xA then 0xB -> count_o=2, in_ready_o=0, 0xC held off; release out_ready_i -> 0xA, 0xB, 0xC in order.
REQ-030 SHALL cover flush in FULL with coincident in-fire attempt (CLEAR_ON_FLUSH=1) -> next cycle count_o=0, out_valid_o=0, out_data_o=0, dropped payload never appears.
REQ-031 SHALL cover saturation with CNT_W=3: hold out_valid_o=1, out_ready_i=0 for 10 cycles -> bp_cnt_o reaches 7 and stays 7.
REQ-032 SHALL cover reset mid-operation: rst_i=1 in FULL with bp_cnt_o=5 -> all outputs at reset values next cycle, bp_cnt_o=0, in_ready_o=1.
